// File: rtl/mcp3202_spi_responder.sv
// MCP3202 ADC emulator: SPI slave that decodes start/SGL/ODD/MSBF and returns a 12-bit sample.
// Define MCP3202_RESP_TIMING_CHECK_EN to build the cs/sck timing checker behind timing_err.
`timescale 1ns/1ps
module mcp3202_spi_responder #(
  parameter int SYNC_STAGES      = 2,
  parameter int TCSH_MIN_CYC     = 50,
  parameter int SCK_HALF_MIN_CYC = 55
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic [11:0] sample_ch0,
  input  logic [11:0] sample_ch1,
  output logic        cfg_sgl,
  output logic        cfg_odd,
  output logic        cfg_msbf,
  output logic        xfer_done,
  output logic        xfer_abort,
  output logic        timing_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_START, S_GET_SGL, S_GET_ODD, S_GET_MSBF,
    S_NULL, S_MSB_OUT, S_LSB_OUT, S_ZERO_OUT
  } state_t;

  // cs syncs to 1 so a reset never looks like a frame start
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic                   sck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  logic cs_s, sck_s, mosi_s, sck_rise, sck_fall;
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [11:0] shift_q, shift_d;
  logic        miso_q, miso_d, miso_oe_q, miso_oe_d;
  logic        sgl_q, sgl_d, odd_q, odd_d, msbf_q, msbf_d;
  logic        done_q, done_d, abort_q, abort_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      sgl_q     <= 1'b0;
      odd_q     <= 1'b0;
      msbf_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      sgl_q     <= sgl_d;
      odd_q     <= odd_d;
      msbf_q    <= msbf_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    sgl_d     = sgl_q;
    odd_d     = odd_q;
    msbf_d    = msbf_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    // cs release outranks any sck edge seen on the same clk
    if (state_q != S_IDLE && cs_s) begin
      state_d   = S_IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      if (state_q == S_LSB_OUT || state_q == S_ZERO_OUT) done_d = 1'b1;
      else                                               abort_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
          if (!cs_s) state_d = S_WAIT_START;
        end
        S_WAIT_START: if (sck_rise && mosi_s) state_d = S_GET_SGL;
        S_GET_SGL: if (sck_rise) begin
          sgl_d   = mosi_s;
          state_d = S_GET_ODD;
        end
        S_GET_ODD: if (sck_rise) begin
          odd_d   = mosi_s;
          state_d = S_GET_MSBF;
        end
        S_GET_MSBF: if (sck_rise) begin
          msbf_d  = mosi_s;
          shift_d = odd_q ? sample_ch1 : sample_ch0;
          state_d = S_NULL;
        end
        S_NULL: if (sck_fall) begin
          miso_oe_d = 1'b1;
          miso_d    = 1'b0;
          bit_cnt_d = 4'd11;
          state_d   = S_MSB_OUT;
        end
        S_MSB_OUT: if (sck_fall) begin
          miso_d = shift_q[bit_cnt_q];
          if (bit_cnt_q == 4'd0) begin
            if (msbf_q) begin
              state_d = S_ZERO_OUT;
            end else begin
              bit_cnt_d = 4'd1;
              state_d   = S_LSB_OUT;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - 4'd1;
          end
        end
        S_LSB_OUT: if (sck_fall) begin
          miso_d = shift_q[bit_cnt_q];
          if (bit_cnt_q == 4'd11) state_d = S_ZERO_OUT;
          else                    bit_cnt_d = bit_cnt_q + 4'd1;
        end
        S_ZERO_OUT: if (sck_fall) miso_d = 1'b0;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = miso_oe_q;
  assign cfg_sgl    = sgl_q;
  assign cfg_odd    = odd_q;
  assign cfg_msbf   = msbf_q;
  assign xfer_done  = done_q;
  assign xfer_abort = abort_q;

`ifdef MCP3202_RESP_TIMING_CHECK_EN
  localparam int TSUCS_CYC = 10;
  localparam int CNT_MAX0  = (TCSH_MIN_CYC > SCK_HALF_MIN_CYC) ? TCSH_MIN_CYC : SCK_HALF_MIN_CYC;
  localparam int CNT_MAX   = (CNT_MAX0 > TSUCS_CYC) ? CNT_MAX0 : TSUCS_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  logic             cs_prev_q, first_frame_q, seen_rise_q, terr_q;
  logic [CNT_W-1:0] tcsh_cnt_q, phase_cnt_q;
  logic             cs_fall;
  assign cs_fall = cs_prev_q & ~cs_s;

  // Counters hold the number of clks since the last boundary, so a phase of N clks reads N
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_prev_q     <= 1'b1;
      first_frame_q <= 1'b1;
      seen_rise_q   <= 1'b0;
      terr_q        <= 1'b0;
      tcsh_cnt_q    <= '0;
      phase_cnt_q   <= '0;
    end else begin
      cs_prev_q <= cs_s;
      if (cs_s) begin
        if (tcsh_cnt_q != '1) tcsh_cnt_q <= tcsh_cnt_q + 1'b1;
        seen_rise_q <= 1'b0;
      end else if (cs_fall) begin
        if (!first_frame_q && tcsh_cnt_q < CNT_W'(TCSH_MIN_CYC)) terr_q <= 1'b1;
        first_frame_q <= 1'b0;
        tcsh_cnt_q    <= '0;
        phase_cnt_q   <= CNT_W'(1);
      end else if (sck_rise || sck_fall) begin
        if (sck_rise && !seen_rise_q) begin
          if (phase_cnt_q < CNT_W'(TSUCS_CYC)) terr_q <= 1'b1;
        end else if (seen_rise_q && phase_cnt_q < CNT_W'(SCK_HALF_MIN_CYC)) begin
          terr_q <= 1'b1;
        end
        seen_rise_q <= seen_rise_q | sck_rise;
        phase_cnt_q <= CNT_W'(1);
      end else if (phase_cnt_q != '1) begin
        phase_cnt_q <= phase_cnt_q + 1'b1;
      end
    end
  end

  assign timing_err = terr_q;
`else
  logic unused_timing_params;
  assign unused_timing_params = ^{32'(TCSH_MIN_CYC), 32'(SCK_HALF_MIN_CYC)};
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// Scoreboarded bench for mcp3202_spi_responder: directed frames, expected words pushed per frame.
`timescale 1ns/1ps
module tb_mcp3202_spi_responder;

`ifdef MCP3202_RESP_TIMING_CHECK_EN
  localparam int HALF_NS = 600;
  localparam bit TCHK    = 1'b1;
`else
  localparam int HALF_NS = 300;
  localparam bit TCHK    = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic [11:0] sample_ch0 = '0, sample_ch1 = '0;
  logic miso, miso_oe, cfg_sgl, cfg_odd, cfg_msbf, xfer_done, xfer_abort, timing_err;

  always #5 clk = ~clk;

  mcp3202_spi_responder dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .sample_ch0(sample_ch0), .sample_ch1(sample_ch1),
    .cfg_sgl(cfg_sgl), .cfg_odd(cfg_odd), .cfg_msbf(cfg_msbf),
    .xfer_done(xfer_done), .xfer_abort(xfer_abort), .timing_err(timing_err)
  );

  typedef struct {
    bit          is_done;
    logic [31:0] rx;
    bit          sgl, odd, msbf, terr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0, n_bad = 0, n_xfer = 0;
  logic [31:0] rx_word = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic cmd_phase(input int lead, input bit sgl, input bit odd, input bit msbf,
                           input bit swap, input logic [11:0] ch1_new);
    logic [3:0] cmd;
    cmd = {1'b1, sgl, odd, msbf};
    for (int i = 0; i < lead + 4; i++) begin
      mosi = (i < lead) ? 1'b0 : cmd[3 - (i - lead)];
      #HALF_NS sck = 1'b1;
      if (i == lead + 3 && swap) begin
        #(HALF_NS / 2) sample_ch1 = ch1_new;
        #(HALF_NS - HALF_NS / 2) sck = 1'b0;
      end else begin
        #HALF_NS sck = 1'b0;
      end
    end
    mosi = 1'b0;
  endtask

  task automatic read_bits(input int n);
    rx_word = '0;
    for (int i = 0; i < n; i++) begin
      #HALF_NS sck = 1'b1;
      rx_word = {rx_word[30:0], miso};
      #HALF_NS sck = 1'b0;
    end
  endtask

  task automatic run(input int lead, input bit sgl, input bit odd, input bit msbf, input int nread,
                     input bit swap, input logic [11:0] ch1_new,
                     input bit is_done, input logic [31:0] exp_rx, input bit terr);
    exp_t e;
    e.is_done = is_done; e.rx = exp_rx; e.sgl = sgl; e.odd = odd; e.msbf = msbf; e.terr = terr;
    sb_q.push_back(e);
    cs = 1'b0;
    cmd_phase(lead, sgl, odd, msbf, swap, ch1_new);
    read_bits(nread);
    #HALF_NS cs = 1'b1;
  endtask

  // Monitor: every done/abort pulse is matched against the oldest expected frame
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (xfer_done || xfer_abort)) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_pulse: got done=%b abort=%b, expected no pulse", xfer_done, xfer_abort);
        end else begin
          e = sb_q.pop_front();
          n_xfer++;
          $display("xfer %0d: done=%b abort=%b rx=%h cfg=%b%b%b oe=%b terr=%b",
                   n_xfer, xfer_done, xfer_abort, rx_word, cfg_sgl, cfg_odd, cfg_msbf, miso_oe, timing_err);
          check("pulse_done",  32'(xfer_done),  32'(e.is_done));
          check("pulse_abort", 32'(xfer_abort), 32'(!e.is_done));
          check("rx_data",     rx_word,         e.rx);
          check("cfg_sgl",     32'(cfg_sgl),    32'(e.sgl));
          check("cfg_odd",     32'(cfg_odd),    32'(e.odd));
          check("cfg_msbf",    32'(cfg_msbf),   32'(e.msbf));
          check("miso_oe_off", 32'(miso_oe),    32'd0);
          check("miso_off",    32'(miso),       32'd0);
          check("timing_err",  32'(timing_err), 32'(e.terr));
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso",   32'(miso),       32'd0);
    check("rst_oe",     32'(miso_oe),    32'd0);
    check("rst_sgl",    32'(cfg_sgl),    32'd0);
    check("rst_odd",    32'(cfg_odd),    32'd0);
    check("rst_msbf",   32'(cfg_msbf),   32'd0);
    check("rst_done",   32'(xfer_done),  32'd0);
    check("rst_abort",  32'(xfer_abort), 32'd0);
    check("rst_terr",   32'(timing_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1000;

    // single-ended ch0, MSB first, 24 sck clocks total
    sample_ch0 = 12'h75F; sample_ch1 = 12'h3C3;
    run(0, 1, 0, 1, 20, 0, 12'h000, 1, {12'h0, 1'b0, 12'h75F, 7'b0}, 0);
    #1000;
    // ODD=1 with sample_ch1 changed after the MSBF rise
    sample_ch0 = 12'h01A; sample_ch1 = 12'h4E8;
    run(0, 1, 1, 1, 20, 1, 12'hFFF, 1, {12'h0, 1'b0, 12'h4E8, 7'b0}, 0);
    #1000;
    // LSB-first tail: B11..B0 then B1..B11 then zeros
    sample_ch0 = 12'h01A;
    run(0, 1, 0, 0, 26, 0, 12'h000, 1, {6'h0, 1'b0, 12'h01A, 11'b101_1000_0000, 2'b00}, 0);
    #1000;
    // two leading zeros before start
    sample_ch0 = 12'h75F;
    run(2, 1, 0, 1, 20, 0, 12'h000, 1, {12'h0, 1'b0, 12'h75F, 7'b0}, 0);
    #1000;
    // differential, ODD=1
    sample_ch1 = 12'hA5C;
    run(0, 0, 1, 1, 13, 0, 12'h000, 1, {19'h0, 1'b0, 12'hA5C}, 0);
    #1000;
    // cs raised after 6 data bits: abort
    sample_ch0 = 12'h75F;
    run(0, 1, 0, 1, 7, 0, 12'h000, 0, {25'h0, 7'b0011101}, 0);
    #1000;

    // reset mid-data: outputs return to reset values without waiting for a clk
    sample_ch1 = 12'h123;
    cs = 1'b0;
    cmd_phase(0, 1, 1, 1, 0, 12'h000);
    read_bits(4);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_miso",  32'(miso),       32'd0);
    check("midrst_oe",    32'(miso_oe),    32'd0);
    check("midrst_sgl",   32'(cfg_sgl),    32'd0);
    check("midrst_odd",   32'(cfg_odd),    32'd0);
    check("midrst_msbf",  32'(cfg_msbf),   32'd0);
    check("midrst_done",  32'(xfer_done),  32'd0);
    check("midrst_abort", 32'(xfer_abort), 32'd0);
    cs = 1'b1; sck = 1'b0;
    #200;
    @(negedge clk) rst_n = 1'b1;
    #1000;
    sample_ch0 = 12'h75F;
    run(0, 1, 0, 1, 20, 0, 12'h000, 1, {12'h0, 1'b0, 12'h75F, 7'b0}, 0);

    // 300 ns cs-high gap: a timing violation only when the checker is built, then sticky
    #300;
    sample_ch0 = 12'h5A5;
    run(0, 1, 0, 1, 13, 0, 12'h000, 1, {19'h0, 1'b0, 12'h5A5}, TCHK);
    #1000;
    run(0, 1, 0, 1, 13, 0, 12'h000, 1, {19'h0, 1'b0, 12'h5A5}, TCHK);

    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    repeat (20) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
